// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1
//   N-input to 1-output stream multiplexer with valid/ready handshakes on every
//   port and a registered output stage. The channel is picked by the sel port.
//   If the macro STREAM_MUX_RR_EN is defined, a round-robin arbiter picks the
//   channel instead, and sel is ignored.
//
// Ports
//   clk        in   1              clock, all state on rising edge
//   rst_n      in   1              asynchronous active-low reset
//   in_data    in   NUM_CH*WIDTH   channel k at bits [k*WIDTH +: WIDTH]
//   in_valid   in   NUM_CH         per-channel valid
//   in_ready   out  NUM_CH         per-channel ready (combinational, one-hot or zero)
//   sel        in   SEL_W          channel select (unused in round-robin build)
//   out_data   out  WIDTH          registered output data
//   out_valid  out  1              registered output valid
//   out_ready  in   1              sink ready
//   out_ch     out  SEL_W          channel that supplied out_data
//   err_sel    out  1              registered flag: last sampled sel was out of range
module stream_mux_nto1 #(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    err_sel
);

    // The output register is the only state: it is either empty or holds a word.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               err_q, err_d;

    logic               load_en;
    logic               xfer;
    logic [SEL_W-1:0]   grant;
    logic               grant_vld;
    logic [WIDTH-1:0]   mux_data;

    // The register can take a new word when it is empty or being drained now.
    assign load_en = (state_q == EMPTY) | out_ready;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   rr_idx;
    logic               unused_sel;

    assign unused_sel = ^sel;

    // Search from rr_ptr+1 upward (mod NUM_CH). The loop runs from the farthest
    // candidate to the nearest one, so the nearest valid channel is the last one written.
    always_comb begin
        grant     = '0;
        rr_idx    = '0;
        grant_vld = |in_valid;
        for (int i = NUM_CH; i >= 1; i--) begin
            rr_idx = SEL_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (in_valid[rr_idx]) begin
                grant = rr_idx;
            end
        end
        err_d    = 1'b0;
        rr_ptr_d = xfer ? grant : rr_ptr_q;
    end

    // The pointer moves only on an accepted word, so stalls do not skip a channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= SEL_W'(NUM_CH - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

    // A select value at or above NUM_CH is possible only when NUM_CH is not a
    // power of two. Such a value grants nothing and is flagged on every cycle it is seen.
    always_comb begin
        grant     = sel;
        grant_vld = ({1'b0, sel} < NUM_CH_EXT);
        err_d     = ~grant_vld;
    end
`endif

    // At most one ready bit is set. Ready is forced low while reset is asserted.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rst_n && load_en && grant_vld && (grant == SEL_W'(k))) begin
                in_ready[k] = 1'b1;
            end
        end
    end

    // in_ready is one-hot, so it can steer the data mux directly.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_ready[k]) begin
                mux_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    // A drain and a load on the same edge simply overwrite the register.
    // A load slot with no incoming word empties the register and keeps the old data.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        if (load_en) begin
            if (xfer) begin
                state_d = FULL;
                data_d  = mux_data;
                ch_d    = grant;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign err_sel   = err_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb_stream_mux_nto1
//   Self-checking bench for stream_mux_nto1. It drives a 4-channel instance
//   through directed scenarios, then through randomized traffic. A behavioural
//   model of the output register and grant rule sets the expected values.
//   A 3-channel instance covers the out-of-range select flag. The bench follows
//   STREAM_MUX_RR_EN when that macro is defined.
module tb_stream_mux_nto1;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_ch;
    logic           err_sel;

    logic [3*W-1:0] cInData;
    logic [2:0]     cInValid;
    logic [2:0]     cInReady;
    logic [1:0]     cSel;
    logic [W-1:0]   cOutData;
    logic           cOutValid;
    logic           cOutReady;
    logic [1:0]     cOutCh;
    logic           cErrSel;

    stream_mux_nto1 #(.NUM_CH(N), .WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .err_sel   (err_sel)
    );

    stream_mux_nto1 #(.NUM_CH(3), .WIDTH(W)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (cInData),
        .in_valid  (cInValid),
        .in_ready  (cInReady),
        .sel       (cSel),
        .out_data  (cOutData),
        .out_valid (cOutValid),
        .out_ready (cOutReady),
        .out_ch    (cOutCh),
        .err_sel   (cErrSel)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what the output register should hold.
    bit          mValid;
    logic [W-1:0] mData;
    int          mCh;
    bit          mErr;
    int          mRr;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid = 1'b0;
        mData  = '0;
        mCh    = 0;
        mErr   = 1'b0;
        mRr    = N - 1;
    endtask

    // Grant rule from the block description. In select mode it is sel when in range.
    // In round-robin mode it is the first valid channel after the last one served.
    function automatic void modelGrant(output bit gv, output int g);
`ifdef STREAM_MUX_RR_EN
        gv = 1'b0;
        g  = 0;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (mRr + i) % N;
            if (!gv && in_valid[k]) begin
                gv = 1'b1;
                g  = k;
            end
        end
`else
        g  = int'(sel);
        gv = (g < N);
`endif
    endfunction

    // Compare everything at the falling edge, then advance the model on the rising edge.
    task automatic applyStimulus(input string tag);
        bit           gv;
        int           g;
        bit           le;
        logic [N-1:0] one;
        logic [N-1:0] expReady;
        @(negedge clk);
        modelGrant(gv, g);
        le       = !mValid || out_ready;
        one      = 1;
        expReady = (le && gv) ? (one << g) : '0;
        checkOutput({tag, "/in_ready"},  32'(in_ready),  32'(expReady));
        checkOutput({tag, "/out_valid"}, 32'(out_valid), 32'(mValid));
        checkOutput({tag, "/out_data"},  32'(out_data),  32'(mData));
        checkOutput({tag, "/out_ch"},    32'(out_ch),    32'(mCh));
        checkOutput({tag, "/err_sel"},   32'(err_sel),   32'(mErr));
        @(posedge clk);
        if (le) begin
            if (gv && in_valid[g]) begin
                mValid = 1'b1;
                mData  = in_data[g*W +: W];
                mCh    = g;
                mRr    = g;
            end else begin
                mValid = 1'b0;
            end
        end
`ifndef STREAM_MUX_RR_EN
        mErr = !gv;
`endif
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = '0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

`ifdef STREAM_MUX_RR_EN
    int rrSeqA[5] = '{0, 1, 2, 3, 0};
    int rrSeqB[4] = '{0, 1, 3, 0};
`endif

    initial begin
        in_data   = '0;
        in_valid  = '1;
        sel       = '0;
        out_ready = 1'b0;
        cInData   = '0;
        cInValid  = '0;
        cSel      = '0;
        cOutReady = 1'b1;
        modelReset();

        // Reset state: nothing is ready and the outputs are at their reset values.
        #3;
        checkOutput("rst/in_ready",  32'(in_ready),  32'h0);
        checkOutput("rst/out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst/out_data",  32'(out_data),  32'h0);
        checkOutput("rst/out_ch",    32'(out_ch),    32'h0);
        checkOutput("rst/err_sel",   32'(err_sel),   32'h0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic select: ch2 carries A5.
        sel                 = 2'd2;
        in_valid            = 4'b0100;
        in_data[2*W +: W]   = 8'hA5;
        out_ready           = 1'b1;
        #1;
        checkOutput("s1/in_ready", 32'(in_ready), 32'h4);
        applyStimulus("s1");
        checkOutput("s1/out_valid", 32'(out_valid), 32'h1);
        checkOutput("s1/out_data",  32'(out_data),  32'hA5);
        checkOutput("s1/out_ch",    32'(out_ch),    32'h2);

        // Stall with 3C held. The next word loads on the same edge as the release.
        in_data[2*W +: W] = 8'h3C;
        applyStimulus("s2load");
        out_ready         = 1'b0;
        in_data[2*W +: W] = 8'h77;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("s2stall");
            checkOutput("s2/held_data", 32'(out_data), 32'h3C);
            checkOutput("s2/held_ch",   32'(out_ch),   32'h2);
            checkOutput("s2/no_ready",  32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        applyStimulus("s2release");
        checkOutput("s2/next_data",  32'(out_data),  32'h77);
        checkOutput("s2/next_valid", 32'(out_valid), 32'h1);

        // Streaming 0..9 from ch1, one word per cycle.
        sel      = 2'd1;
        in_valid = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            in_data[1*W +: W] = W'(i);
            applyStimulus("s3");
            checkOutput("s3/out_data",  32'(out_data),  32'(i));
            checkOutput("s3/out_valid", 32'(out_valid), 32'h1);
            checkOutput("s3/out_ch",    32'(out_ch),    32'h1);
        end
        in_valid = '0;
        applyStimulus("s3drain");
        checkOutput("s3/empty", 32'(out_valid), 32'h0);

        // Reset while full and back-pressured.
        sel               = 2'd2;
        in_valid          = 4'b0100;
        in_data[2*W +: W] = 8'hC3;
        applyStimulus("s5load");
        out_ready = 1'b0;
        in_valid  = '0;
        applyStimulus("s5full");
        #2;
        rst_n    = 1'b0;
        in_valid = '1;
        #1;
        checkOutput("s5/async_valid", 32'(out_valid), 32'h0);
        checkOutput("s5/rst_ready",   32'(in_ready),  32'h0);
        modelReset();
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        sel               = 2'd2;
        in_valid          = 4'b0100;
        in_data[2*W +: W] = 8'h5A;
        out_ready         = 1'b1;
        #1;
        checkOutput("s5/in_ready", 32'(in_ready), 32'h4);
        applyStimulus("s5again");
        checkOutput("s5/out_data", 32'(out_data), 32'h5A);
        checkOutput("s5/out_ch",   32'(out_ch),   32'h2);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = N'($urandom);
            in_data   = $urandom;
            sel       = SW'($urandom_range(0, N - 1));
            out_ready = ($urandom % 4) != 0;
            applyStimulus("rand");
        end

`ifndef STREAM_MUX_RR_EN
        // Out-of-range select on the 3-channel instance.
        @(negedge clk);
        cSel     = 2'd3;
        cInValid = 3'b111;
        cInData  = {8'h33, 8'h22, 8'h11};
        #1;
        checkOutput("s4/in_ready", 32'(cInReady), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("s4/err_set",   32'(cErrSel),   32'h1);
        checkOutput("s4/out_valid", 32'(cOutValid), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("s4/err_hold",   32'(cErrSel),   32'h1);
        checkOutput("s4/still_empty", 32'(cOutValid), 32'h0);
        cSel = 2'd0;
        #1;
        checkOutput("s4/ready_ch0", 32'(cInReady), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("s4/err_clr",  32'(cErrSel),   32'h0);
        checkOutput("s4/valid",    32'(cOutValid), 32'h1);
        checkOutput("s4/data",     32'(cOutData),  32'h11);
        checkOutput("s4/ch",       32'(cOutCh),    32'h0);
`else
        // Round-robin order from reset.
        doReset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus("rrA");
            checkOutput("rrA/out_ch", 32'(out_ch), 32'(rrSeqA[i]));
        end
        doReset();
        in_valid  = 4'b1011;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus("rrB");
            checkOutput("rrB/out_ch", 32'(out_ch), 32'(rrSeqB[i]));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
